// File: rtl/mem_io_responder.sv
// Byte-wide memory responder for memCtrl: RAM at addr[17]=0, I/O (UART TX/RX, halt) at addr[17]=1.
// Optional `IO_CYCLE_COUNT_EN adds a cycle counter with a coherent 4-byte snapshot at 0x30008..B.
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int TXQ_LOG     = 3,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rdy,
    input  logic [7:0]  i_mc_to_mem_dout,
    input  logic [31:0] i_mc_to_mem_addr,
    input  logic        i_mc_to_mem_wr,
    output logic [7:0]  o_mem_to_mc_din,
    output logic        o_io_buffer_full,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_pop,
    output logic        o_halt,
    output logic        o_tx_overflow
);
    localparam int DEPTH = 1 << TXQ_LOG;

    logic [7:0]         r_ram [2**RAM_AW];
    logic [7:0]         r_txq [DEPTH];
    logic [TXQ_LOG-1:0] r_wr_ptr, r_rd_ptr;
    logic [TXQ_LOG:0]   r_cnt;
    logic [7:0]         r_din;
    logic               r_rx_pop, r_halt, r_ovf;

    logic              w_is_io, w_rd, w_push_req, w_push_ok, w_pop, w_full;
    logic              w_ram_we, w_halt_set, w_rx_take;
    logic [3:0]        w_off;
    logic [7:0]        w_io_dat;
    logic [TXQ_LOG:0]  w_free;
    logic              w_unused_addr;

    assign w_is_io       = i_mc_to_mem_addr[17];
    assign w_off         = i_mc_to_mem_addr[3:0];
    assign w_rd          = i_rdy & ~i_mc_to_mem_wr;
    assign w_ram_we      = i_rdy & i_mc_to_mem_wr & ~w_is_io & ~rst;
    assign w_push_req    = i_rdy & i_mc_to_mem_wr & w_is_io & (w_off == 4'h0);
    assign w_halt_set    = i_rdy & i_mc_to_mem_wr & w_is_io & (w_off == 4'h4);
    assign w_rx_take     = w_rd & w_is_io & (w_off == 4'h0) & i_rx_valid;
    assign w_full        = (r_cnt == (TXQ_LOG+1)'(DEPTH));
    assign w_pop         = i_rdy & o_tx_valid & i_tx_ready;
    // When full, a simultaneous pop frees the head slot, which is also the tail slot.
    assign w_push_ok     = w_push_req & (~w_full | w_pop);
    assign w_free        = (TXQ_LOG+1)'(DEPTH) - r_cnt;
    assign w_unused_addr = ^i_mc_to_mem_addr[31:18];

    assign o_io_buffer_full = (w_free <= (TXQ_LOG+1)'(FULL_MARGIN));
    assign o_tx_valid       = (r_cnt != '0);
    assign o_tx_data        = r_txq[r_rd_ptr];
    assign o_mem_to_mc_din  = r_din;
    assign o_rx_pop         = r_rx_pop;
    assign o_halt           = r_halt;
    assign o_tx_overflow    = r_ovf;

`ifdef IO_CYCLE_COUNT_EN
    logic [31:0] r_cyc, r_snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc  <= '0;
            r_snap <= '0;
        end else if (i_rdy) begin
            r_cyc <= r_cyc + 32'd1;
            if (~i_mc_to_mem_wr & w_is_io & (w_off == 4'h8))
                r_snap <= r_cyc;
        end
    end
`endif

    always_comb begin
        w_io_dat = 8'h00;
        case (w_off)
            4'h0: w_io_dat = i_rx_valid ? i_rx_data : 8'h00;
            4'h4: w_io_dat = {7'b0, ~o_tx_valid};
`ifdef IO_CYCLE_COUNT_EN
            4'h8: w_io_dat = r_cyc[7:0];
            4'h9: w_io_dat = r_snap[15:8];
            4'hA: w_io_dat = r_snap[23:16];
            4'hB: w_io_dat = r_snap[31:24];
`endif
            default: w_io_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[i_mc_to_mem_addr[RAM_AW-1:0]] <= i_mc_to_mem_dout;
    end

    // Read data is captured on every ready cycle; a write cycle returns the pre-write byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din    <= '0;
            r_rx_pop <= 1'b0;
            r_halt   <= 1'b0;
        end else begin
            r_rx_pop <= w_rx_take;
            if (i_rdy)
                r_din <= w_is_io ? w_io_dat : r_ram[i_mc_to_mem_addr[RAM_AW-1:0]];
            if (w_halt_set)
                r_halt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_txq[r_wr_ptr] <= i_mc_to_mem_dout;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_req & ~w_push_ok)
                r_ovf <= 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule
